// File: rtl/jtframe_credits_pkg.sv
// Shared types and sizes for the credits/pause overlay sequencer.
package jtframe_credits_pkg;

  localparam int unsigned VRAM_AW    = 10;
  localparam int unsigned VRAM_DEPTH = 1024;
  localparam int unsigned VRAM_DW    = 8;
  localparam int unsigned CTRL_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // One VRAM write: address plus data byte
  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] din;
  } vram_wr_t;

endpackage

// File: rtl/jtframe_credits_seq_if.sv
// Text requester write port: requester holds req/addr/din, sequencer answers with a one-cycle ack.
interface jtframe_credits_seq_if;
  import jtframe_credits_pkg::*;

  logic               req;
  logic [VRAM_AW-1:0] addr;
  logic [VRAM_DW-1:0] din;
  logic               ack;

  modport master (output req, output addr, output din, input  ack);
  modport slave  (input  req, input  addr, input  din, output ack);

endinterface

// File: rtl/jtframe_credits_arb.sv
// Two-way round-robin arbiter for the overlay VRAM write port; grant decision is combinational.
module jtframe_credits_arb
  import jtframe_credits_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     a_req,
  input  vram_wr_t a_wr,
  input  logic     b_req,
  input  vram_wr_t b_wr,
  output logic     gnt_a_c,
  output logic     gnt_b_c,
  output logic     we_c,
  output vram_wr_t wr_c
);

  logic rr_b;  // 0: A wins the next contention, 1: B wins

  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (en) begin
      if (a_req && b_req) begin
        gnt_a_c = ~rr_b;
        gnt_b_c = rr_b;
      end else begin
        gnt_a_c = a_req;
        gnt_b_c = b_req;
      end
    end
    we_c = gnt_a_c | gnt_b_c;
    wr_c = gnt_b_c ? b_wr : a_wr;
  end

  // Pointer only moves when both requesters competed
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_b <= 1'b0;
    end else if (en && a_req && b_req) begin
      rr_b <= ~rr_b;
    end
  end

endmodule

// File: rtl/jtframe_credits_seq.sv
// Credits/pause overlay sequencer: clears message VRAM on pause entry, then arbitrates
// two text requesters and drives the overlay enable/toggle/fast_scroll/vram_ctrl controls.
module jtframe_credits_seq
  import jtframe_credits_pkg::*;
#(
  parameter bit                 CLR_EN   = 1'b1,
  parameter logic [VRAM_DW-1:0] CLR_CHAR = 8'h20,
  parameter int unsigned        AUTOHIDE = 0,
  parameter int unsigned        FASTDLY  = 4
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               pause,
  input  logic               vb,
  input  logic               btn_toggle,
  input  logic               btn_fast,
  input  logic [CTRL_W-1:0]  cfg_vram_ctrl,
  jtframe_credits_seq_if.slave a,
  jtframe_credits_seq_if.slave b,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_din,
  output logic               vram_we,
  output logic               enable,
  output logic               toggle,
  output logic               fast_scroll,
  output logic [CTRL_W-1:0]  vram_ctrl,
  output logic               busy
);

  localparam int unsigned AH_W = 8;
  localparam int unsigned FD_W = 4;
  localparam logic [AH_W-1:0]    AH_MAX   = AH_W'(AUTOHIDE);
  localparam logic [FD_W-1:0]    FD_MAX   = FD_W'(FASTDLY);
  localparam logic [FD_W-1:0]    FD_SAT   = '1;
  localparam logic [VRAM_AW-1:0] CLR_LAST = VRAM_AW'(VRAM_DEPTH - 1);

  state_t state, state_nxt;

  logic pause_q, vb_q, tog_q;
  logic pause_rise, pause_fall, vb_rise, tog_rise;

  logic [AH_W-1:0]    fcnt, fcnt_nxt;
  logic [FD_W-1:0]    fast_cnt, fast_cnt_nxt;
  logic               ah_hit;

  logic               a_ack_q, b_ack_q, a_ack_nxt, b_ack_nxt;
  logic [VRAM_AW-1:0] addr_nxt;
  logic [VRAM_DW-1:0] din_nxt;
  logic               we_nxt, enable_nxt, toggle_nxt, fast_nxt, busy_nxt;
  logic [CTRL_W-1:0]  ctrl_nxt;

  vram_wr_t a_wr, b_wr, arb_wr_c;
  logic     arb_en_c, gnt_a_c, gnt_b_c, arb_we_c;

  assign pause_rise = pause & ~pause_q;
  assign pause_fall = ~pause & pause_q;
  assign vb_rise    = vb & ~vb_q;
  assign tog_rise   = btn_toggle & ~tog_q;

  assign a_wr.addr = a.addr;
  assign a_wr.din  = a.din;
  assign b_wr.addr = b.addr;
  assign b_wr.din  = b.din;
  assign a.ack     = a_ack_q;
  assign b.ack     = b_ack_q;

  // Requests are only served in SHOW, and not on the cycle that leaves it
  assign arb_en_c = (state == SHOW) && !pause_fall;

  jtframe_credits_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en_c),
    .a_req   (a.req),
    .a_wr    (a_wr),
    .b_req   (b.req),
    .b_wr    (b_wr),
    .gnt_a_c (gnt_a_c),
    .gnt_b_c (gnt_b_c),
    .we_c    (arb_we_c),
    .wr_c    (arb_wr_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_nxt    = state;
    busy_nxt     = 1'b0;
    we_nxt       = 1'b0;
    addr_nxt     = vram_addr;
    din_nxt      = vram_din;
    enable_nxt   = enable;
    ctrl_nxt     = vram_ctrl;
    toggle_nxt   = 1'b0;
    a_ack_nxt    = 1'b0;
    b_ack_nxt    = 1'b0;
    fcnt_nxt     = '0;
    fast_cnt_nxt = '0;
    fast_nxt     = 1'b0;
    ah_hit       = 1'b0;

    case (state)
      IDLE: begin
        enable_nxt = 1'b0;
        if (pause_rise) begin
          if (CLR_EN) begin
            state_nxt = CLEAR;
            busy_nxt  = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = '0;
            din_nxt   = CLR_CHAR;
          end else begin
            state_nxt  = SHOW;
            enable_nxt = 1'b1;
            ctrl_nxt   = cfg_vram_ctrl;
          end
        end
      end

      CLEAR: begin
        if (pause_fall) begin
          state_nxt  = IDLE;
          enable_nxt = 1'b0;
        end else if (vram_addr == CLR_LAST) begin
          state_nxt  = SHOW;
          enable_nxt = 1'b1;
          ctrl_nxt   = cfg_vram_ctrl;
        end else begin
          busy_nxt = 1'b1;
          we_nxt   = 1'b1;
          addr_nxt = vram_addr + VRAM_AW'(1);
          din_nxt  = CLR_CHAR;
        end
      end

      SHOW: begin
        if (pause_fall) begin
          state_nxt  = IDLE;
          enable_nxt = 1'b0;
        end else begin
          we_nxt    = arb_we_c;
          a_ack_nxt = gnt_a_c;
          b_ack_nxt = gnt_b_c;
          if (arb_we_c) begin
            addr_nxt = arb_wr_c.addr;
            din_nxt  = arb_wr_c.din;
          end
          // Idle-frame counter saturates at AUTOHIDE so the hide pulse fires once
          if (arb_we_c || tog_rise) begin
            fcnt_nxt = '0;
          end else if (vb_rise && (fcnt < AH_MAX)) begin
            fcnt_nxt = fcnt + AH_W'(1);
            ah_hit   = (fcnt_nxt == AH_MAX);
          end else begin
            fcnt_nxt = fcnt;
          end
          toggle_nxt = tog_rise | ah_hit;
          if (btn_fast) begin
            fast_cnt_nxt = (vb_rise && (fast_cnt != FD_SAT)) ? fast_cnt + FD_W'(1) : fast_cnt;
          end
          fast_nxt = btn_fast && (fast_cnt_nxt >= FD_MAX);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_q     <= 1'b0;
      vb_q        <= 1'b0;
      tog_q       <= 1'b0;
      fcnt        <= '0;
      fast_cnt    <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      vram_addr   <= '0;
      vram_din    <= '0;
      vram_we     <= 1'b0;
      enable      <= 1'b0;
      toggle      <= 1'b0;
      fast_scroll <= 1'b0;
      vram_ctrl   <= '0;
      busy        <= 1'b0;
    end else begin
      pause_q     <= pause;
      vb_q        <= vb;
      tog_q       <= btn_toggle;
      fcnt        <= fcnt_nxt;
      fast_cnt    <= fast_cnt_nxt;
      a_ack_q     <= a_ack_nxt;
      b_ack_q     <= b_ack_nxt;
      vram_addr   <= addr_nxt;
      vram_din    <= din_nxt;
      vram_we     <= we_nxt;
      enable      <= enable_nxt;
      toggle      <= toggle_nxt;
      fast_scroll <= fast_nxt;
      vram_ctrl   <= ctrl_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
